// File: rtl/multi_top.sv
// multi_top: self-contained 8x8 integer matrix-multiply engine, Z = X * Y.
//
// X and Y are internal 64-entry operand stores that hold X[a] = Y[a] = a
// after reset. Z is a 64-entry result store that is cleared at reset. All
// matrices are row-major, with addr = 8*row + col. A rising edge on start
// runs one multiply: one MAC per cycle, and 9 cycles per result element.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   start      multiply request; acted on at its rising edge
//   done       sticky completion flag
//   z_rd_addr  result read address (row*8 + col)
//   z_dout     Z[z_rd_addr], combinational read
//
// Optional feature: macro MULTI_TOP_LOAD_EN adds the ports load_x_we,
// load_y_we, load_addr and load_data. These ports write the X and Y stores
// while the engine is not in RUN.
//
// State table:
//   IDLE | waiting for the first start edge
//   RUN  | computing Z one MAC per cycle
//   DONE | results valid, done = 1; a start edge starts a new run
module multi_top #(
  parameter int N = 8,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         done,
  input  logic [5:0]   z_rd_addr,
`ifdef MULTI_TOP_LOAD_EN
  input  logic         load_x_we,
  input  logic         load_y_we,
  input  logic [5:0]   load_addr,
  input  logic [W-1:0] load_data,
`endif
  output logic [W-1:0] z_dout
);

  localparam int NN = N * N;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]   state;
  logic         start_q;
  logic [2:0]   i;
  logic [2:0]   j;
  logic [3:0]   k;        // 0..7 = MAC cycles, 8 = write-back cycle
  logic [W-1:0] acc;

  logic [W-1:0] x_mem [NN];
  logic [W-1:0] y_mem [NN];
  logic [W-1:0] z_mem [NN];

  logic         start_edge;
  logic         write_cycle;
  logic [W-1:0] x_op;
  logic [W-1:0] y_op;
  logic [W-1:0] prod;

  assign start_edge  = start & ~start_q;
  assign write_cycle = (k == 4'd8);
  assign x_op        = x_mem[{i, k[2:0]}];
  assign y_op        = y_mem[{k[2:0], j}];
  // The product is truncated to W bits and accumulation wraps modulo 2^W.
  assign prod        = x_op * y_op;
  assign z_dout      = z_mem[z_rd_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q <= 1'b0;
    end else begin
      start_q <= start;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
      i     <= 3'd0;
      j     <= 3'd0;
      k     <= 4'd0;
      acc   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_edge) begin
            state <= RUN;
            done  <= 1'b0;
            i     <= 3'd0;
            j     <= 3'd0;
            k     <= 4'd0;
            acc   <= '0;
          end else begin
            done  <= (state == DONE);
          end
        end
        RUN: begin
          if (!write_cycle) begin
            acc <= acc + prod;
            k   <= k + 4'd1;
          end else begin
            acc <= '0;
            k   <= 4'd0;
            if (i == 3'd7 && j == 3'd7) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              j <= j + 3'd1;
              if (j == 3'd7) begin
                i <= i + 3'd1;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int a = 0; a < NN; a++) begin
        x_mem[a] <= W'(a);
        y_mem[a] <= W'(a);
      end
    end
`ifdef MULTI_TOP_LOAD_EN
    else if (state != RUN) begin
      if (load_x_we) begin
        x_mem[load_addr] <= load_data;
      end
      if (load_y_we) begin
        y_mem[load_addr] <= load_data;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int a = 0; a < NN; a++) begin
        z_mem[a] <= '0;
      end
    end else if (state == RUN && write_cycle) begin
      z_mem[{i, j}] <= acc;
    end
  end

endmodule

// File: tb/tb_multi_top.sv
// Directed testbench for multi_top.
module tb_multi_top;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        done;
  logic [5:0]  z_rd_addr;
  logic [31:0] z_dout;
`ifdef MULTI_TOP_LOAD_EN
  logic        load_x_we;
  logic        load_y_we;
  logic [5:0]  load_addr;
  logic [31:0] load_data;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multi_top dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .done      (done),
    .z_rd_addr (z_rd_addr),
`ifdef MULTI_TOP_LOAD_EN
    .load_x_we (load_x_we),
    .load_y_we (load_y_we),
    .load_addr (load_addr),
    .load_data (load_data),
`endif
    .z_dout    (z_dout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Default contents: Z[i][j] = sum_k (8i+k)(8k+j) = 1792i + 64ij + 28j + 1120
  function automatic logic [31:0] z_default(input int a);
    int r;
    int c;
    r = a / 8;
    c = a % 8;
    return 32'(1792 * r + 64 * r * c + 28 * c + 1120);
  endfunction

  function automatic logic [31:0] z_read(input logic [5:0] a);
    return 32'(0);
  endfunction

  task automatic read_z(input logic [5:0] a, output logic [31:0] v);
    z_rd_addr = a;
    #1;
    v = z_dout;
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] v;
    for (int a = 0; a < 64; a++) begin
      read_z(6'(a), v);
      check(tag, v, 32'd0);
    end
  endtask

  task automatic check_all_default(input string tag);
    logic [31:0] v;
    for (int a = 0; a < 64; a++) begin
      read_z(6'(a), v);
      check(tag, v, z_default(a));
    end
  endtask

  task automatic do_reset(input logic start_val);
    @(negedge clk);
    reset = 1'b1;
    start = start_val;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at the negedge just after the start edge was sampled (edge E0).
  // done must still be low after E575 and must be high after E576.
  task automatic wait_run(input string tag);
    check({tag, "_done_cleared"}, {31'd0, done}, 32'd0);
    repeat (575) @(posedge clk);
    @(negedge clk);
    check({tag, "_done_early"}, {31'd0, done}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_on_time"}, {31'd0, done}, 32'd1);
  endtask

  task automatic pulse_start(input logic hold);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    int          bad;
    reset     = 1'b1;
    start     = 1'b0;
    z_rd_addr = 6'd0;
`ifdef MULTI_TOP_LOAD_EN
    load_x_we = 1'b0;
    load_y_we = 1'b0;
    load_addr = 6'd0;
    load_data = 32'd0;
`endif

    // Reset state, with start held low
    do_reset(1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_done", {31'd0, done}, 32'd0);
    check_all_zero("reset_z");

    // One-cycle start pulse
    pulse_start(1'b0);
    wait_run("pulse");
    read_z(6'd0, v);  check("z0", v, 32'd1120);
    read_z(6'd7, v);  check("z7", v, 32'd1316);
    read_z(6'd56, v); check("z56", v, 32'd13664);
    read_z(6'd63, v); check("z63", v, 32'd16996);
    check_all_default("pulse_z");

    // Drop start and raise it again in DONE: the engine recomputes and done rises again
    pulse_start(1'b1);
    wait_run("rerun");
    check_all_default("rerun_z");
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (done !== 1'b1) bad++;
    end
    check("rerun_hold_done", 32'(bad), 32'd0);
    start = 1'b0;

    // Start held high out of reset: exactly one run
    do_reset(1'b1);
    @(posedge clk);
    @(negedge clk);
    wait_run("held");
    bad = 0;
    repeat (700) begin
      @(negedge clk);
      if (done !== 1'b1) bad++;
    end
    check("held_no_rerun", 32'(bad), 32'd0);
    read_z(6'd63, v); check("held_z63", v, 32'd16996);
    start = 1'b0;

    // Reset in the middle of a run
    pulse_start(1'b0);
    repeat (299) @(posedge clk);
    @(negedge clk);
    check("midrun_busy", {31'd0, done}, 32'd0);
    do_reset(1'b0);
    @(posedge clk);
    @(negedge clk);
    check("midrun_reset_done", {31'd0, done}, 32'd0);
    check_all_zero("midrun_reset_z");
    pulse_start(1'b0);
    wait_run("after_abort");
    read_z(6'd63, v); check("after_abort_z63", v, 32'd16996);

`ifdef MULTI_TOP_LOAD_EN
    // Load X = identity and keep Y at its default; expect Z[a] = a
    do_reset(1'b0);
    for (int a = 0; a < 64; a++) begin
      load_x_we = 1'b1;
      load_addr = 6'(a);
      load_data = (a % 9 == 0) ? 32'd1 : 32'd0;
      @(posedge clk);
      @(negedge clk);
    end
    load_x_we = 1'b0;
    pulse_start(1'b0);
    @(posedge clk);
    @(negedge clk);
    // These writes happen during RUN and must be ignored
    load_x_we = 1'b1;
    load_y_we = 1'b1;
    load_addr = 6'd0;
    load_data = 32'd999;
    @(posedge clk);
    @(negedge clk);
    load_x_we = 1'b0;
    load_y_we = 1'b0;
    repeat (600) @(posedge clk);
    @(negedge clk);
    check("load_done", {31'd0, done}, 32'd1);
    for (int a = 0; a < 64; a++) begin
      read_z(6'(a), v);
      check("load_identity_z", v, 32'(a));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
